// File: rtl/tblink_rpc_cmd_pkg.sv
// Shared types for the tblink RPC command client: FSM state encodings and a
// byte-count saturation helper used by both mailbox directions.
// No ports; imported by tblink_rpc_cmd_mbox_rx and tblink_rpc_cmd_client.
package tblink_rpc_cmd_pkg;

  // Inbound mailbox consumer states.
  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_REQ      = 2'd1,
    RX_WAIT_RSP = 2'd2,
    RX_ACK      = 2'd3
  } rx_state_t;

  // Outbound mailbox producer states.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_POST = 2'd1,
    TX_WAIT = 2'd2,
    TX_RSP  = 2'd3
  } tx_state_t;

  // Clamp a byte count to the capacity of the buffer it describes.
  function automatic logic [7:0] sat_sz(input logic [7:0] sz, input logic [7:0] max_sz);
    return (sz > max_sz) ? max_sz : sz;
  endfunction

endpackage

// File: rtl/tblink_rpc_cmd_mbox_rx.sv
// Purpose: inbound mailbox consumer; turns a pending cmd_in* command into a
//   ready/valid request and writes the user's response back to the mailbox.
// Latency: pending -> ireq_valid 1 cycle; irsp handshake -> cmd_in_rsp 1 cycle,
//   -> cmd_in_get_i toggle 2 cycles; 4 cycles minimum per command.
// Backpressure: ireq payload held while ireq_ready=0; irsp_ready only in WAIT_RSP.
// Ports: uclock/reset; cmd_in* mailbox side (put in, get/rsp out);
//   ireq_* request channel (out) and irsp_* response channel (in).
module tblink_rpc_cmd_mbox_rx
  import tblink_rpc_cmd_pkg::*;
#(
  parameter int CMD_IN_PARAMS_SZ = 4,
  parameter int CMD_IN_RSP_SZ    = 4
) (
  input  logic                          uclock,
  input  logic                          reset,
  // mailbox side
  input  logic [7:0]                    cmd_in,
  input  logic [7:0]                    cmd_in_sz,
  input  logic [CMD_IN_PARAMS_SZ*8-1:0] cmd_in_params,
  input  logic                          cmd_in_put_i,
  output logic                          cmd_in_get_i,
  output logic [CMD_IN_RSP_SZ*8-1:0]    cmd_in_rsp,
  output logic [7:0]                    cmd_in_rsp_sz,
  // user request channel
  output logic                          ireq_valid,
  input  logic                          ireq_ready,
  output logic [7:0]                    ireq_cmd,
  output logic [7:0]                    ireq_sz,
  output logic [CMD_IN_PARAMS_SZ*8-1:0] ireq_params,
  // user response channel
  input  logic                          irsp_valid,
  output logic                          irsp_ready,
  input  logic [CMD_IN_RSP_SZ*8-1:0]    irsp_data,
  input  logic [7:0]                    irsp_sz
);

  localparam logic [7:0] RSP_SZ_MAX = 8'(CMD_IN_RSP_SZ);

  rx_state_t state;

  always_ff @(posedge uclock) begin
    if (reset) begin
      state         <= RX_IDLE;
      ireq_valid    <= 1'b0;
      ireq_cmd      <= '0;
      ireq_sz       <= '0;
      ireq_params   <= '0;
      irsp_ready    <= 1'b0;
      cmd_in_rsp    <= '0;
      cmd_in_rsp_sz <= '0;
      cmd_in_get_i  <= 1'b0;
    end else begin
      case (state)
        // The mailbox indices are only compared here, so a command that is
        // still being serviced can never be picked up a second time.
        RX_IDLE: begin
          if (cmd_in_put_i != cmd_in_get_i) begin
            ireq_cmd    <= cmd_in;
            ireq_sz     <= cmd_in_sz;
            ireq_params <= cmd_in_params;
            ireq_valid  <= 1'b1;
            state       <= RX_REQ;
          end
        end
        // ireq_valid is high for the whole of this state.
        RX_REQ: begin
          if (ireq_ready) begin
            ireq_valid <= 1'b0;
            irsp_ready <= 1'b1;
            state      <= RX_WAIT_RSP;
          end
        end
        RX_WAIT_RSP: begin
          if (irsp_valid) begin
            irsp_ready    <= 1'b0;
            cmd_in_rsp    <= irsp_data;
            cmd_in_rsp_sz <= sat_sz(irsp_sz, RSP_SZ_MAX);
            state         <= RX_ACK;
          end
        end
        // The response registers settled a cycle ago; releasing the slot now
        // guarantees cmdproc never sees get move ahead of the data.
        RX_ACK: begin
          cmd_in_get_i <= ~cmd_in_get_i;
          state        <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tblink_rpc_cmd_client.sv
// Purpose: client endpoint of the tblink_rpc_cmdproc mailboxes; inbound commands
//   become ireq/irsp transactions, oreq/orsp transactions become outbound commands.
// Latency: inbound see tblink_rpc_cmd_mbox_rx; outbound oreq handshake -> cmd_out*
//   1 cycle -> cmd_out_put_i toggle 2 cycles; get==put -> orsp_valid 1 cycle.
// Backpressure: one outbound command in flight; oreq_ready only in IDLE;
//   orsp payload held until orsp_ready.
// Ports: uclock/reset; cmd_in*/cmd_out* mailbox sides; ireq/irsp and oreq/orsp
//   user channels (ready/valid).
module tblink_rpc_cmd_client
  import tblink_rpc_cmd_pkg::*;
#(
  parameter int CMD_IN_PARAMS_SZ  = 4,
  parameter int CMD_IN_RSP_SZ     = 4,
  parameter int CMD_OUT_PARAMS_SZ = 4,
  parameter int CMD_OUT_RSP_SZ    = 4
) (
  input  logic                           uclock,
  input  logic                           reset,
  // inbound mailbox
  input  logic [7:0]                     cmd_in,
  input  logic [7:0]                     cmd_in_sz,
  input  logic [CMD_IN_PARAMS_SZ*8-1:0]  cmd_in_params,
  input  logic                           cmd_in_put_i,
  output logic                           cmd_in_get_i,
  output logic [CMD_IN_RSP_SZ*8-1:0]     cmd_in_rsp,
  output logic [7:0]                     cmd_in_rsp_sz,
  // outbound mailbox
  output logic [7:0]                     cmd_out,
  output logic [7:0]                     cmd_out_sz,
  output logic [CMD_OUT_PARAMS_SZ*8-1:0] cmd_out_params,
  output logic                           cmd_out_put_i,
  input  logic                           cmd_out_get_i,
  input  logic [CMD_OUT_RSP_SZ*8-1:0]    cmd_out_rsp,
  input  logic [7:0]                     cmd_out_rsp_sz,
  // inbound user channels
  output logic                           ireq_valid,
  input  logic                           ireq_ready,
  output logic [7:0]                     ireq_cmd,
  output logic [7:0]                     ireq_sz,
  output logic [CMD_IN_PARAMS_SZ*8-1:0]  ireq_params,
  input  logic                           irsp_valid,
  output logic                           irsp_ready,
  input  logic [CMD_IN_RSP_SZ*8-1:0]     irsp_data,
  input  logic [7:0]                     irsp_sz,
  // outbound user channels
  input  logic                           oreq_valid,
  output logic                           oreq_ready,
  input  logic [7:0]                     oreq_cmd,
  input  logic [7:0]                     oreq_sz,
  input  logic [CMD_OUT_PARAMS_SZ*8-1:0] oreq_params,
  output logic                           orsp_valid,
  input  logic                           orsp_ready,
  output logic [CMD_OUT_RSP_SZ*8-1:0]    orsp_data,
  output logic [7:0]                     orsp_sz
);

  localparam logic [7:0] OUT_SZ_MAX = 8'(CMD_OUT_PARAMS_SZ);

  // Inbound direction: fully independent of the outbound FSM below.
  tblink_rpc_cmd_mbox_rx #(
    .CMD_IN_PARAMS_SZ (CMD_IN_PARAMS_SZ),
    .CMD_IN_RSP_SZ    (CMD_IN_RSP_SZ)
  ) u_mbox_rx (
    .uclock        (uclock),
    .reset         (reset),
    .cmd_in        (cmd_in),
    .cmd_in_sz     (cmd_in_sz),
    .cmd_in_params (cmd_in_params),
    .cmd_in_put_i  (cmd_in_put_i),
    .cmd_in_get_i  (cmd_in_get_i),
    .cmd_in_rsp    (cmd_in_rsp),
    .cmd_in_rsp_sz (cmd_in_rsp_sz),
    .ireq_valid    (ireq_valid),
    .ireq_ready    (ireq_ready),
    .ireq_cmd      (ireq_cmd),
    .ireq_sz       (ireq_sz),
    .ireq_params   (ireq_params),
    .irsp_valid    (irsp_valid),
    .irsp_ready    (irsp_ready),
    .irsp_data     (irsp_data),
    .irsp_sz       (irsp_sz)
  );

  // Outbound direction.
  tx_state_t tx_state;

  always_ff @(posedge uclock) begin
    if (reset) begin
      tx_state       <= TX_IDLE;
      oreq_ready     <= 1'b0;
      cmd_out        <= '0;
      cmd_out_sz     <= '0;
      cmd_out_params <= '0;
      cmd_out_put_i  <= 1'b0;
      orsp_valid     <= 1'b0;
      orsp_data      <= '0;
      orsp_sz        <= '0;
    end else begin
      case (tx_state)
        // oreq_ready is registered, so it reads 0 for the first cycle after
        // reset and the handshake only counts once it is visibly high.
        TX_IDLE: begin
          oreq_ready <= 1'b1;
          if (oreq_valid && oreq_ready) begin
            cmd_out        <= oreq_cmd;
            cmd_out_sz     <= sat_sz(oreq_sz, OUT_SZ_MAX);
            cmd_out_params <= oreq_params;
            oreq_ready     <= 1'b0;
            tx_state       <= TX_POST;
          end
        end
        // Payload registers were written last cycle, so they are already
        // stable when cmdproc sees the put index move.
        TX_POST: begin
          cmd_out_put_i <= ~cmd_out_put_i;
          tx_state      <= TX_WAIT;
        end
        TX_WAIT: begin
          if (cmd_out_get_i == cmd_out_put_i) begin
            orsp_data  <= cmd_out_rsp;
            orsp_sz    <= cmd_out_rsp_sz;
            orsp_valid <= 1'b1;
            tx_state   <= TX_RSP;
          end
        end
        TX_RSP: begin
          if (orsp_ready) begin
            orsp_valid <= 1'b0;
            oreq_ready <= 1'b1;
            tx_state   <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tblink_rpc_cmd_client.sv
module tb_tblink_rpc_cmd_client;

  logic        uclock;
  logic        reset;
  logic [7:0]  cmd_in, cmd_in_sz;
  logic [31:0] cmd_in_params;
  logic        cmd_in_put_i;
  logic        cmd_in_get_i;
  logic [31:0] cmd_in_rsp;
  logic [7:0]  cmd_in_rsp_sz;
  logic [7:0]  cmd_out, cmd_out_sz;
  logic [31:0] cmd_out_params;
  logic        cmd_out_put_i;
  logic        cmd_out_get_i;
  logic [31:0] cmd_out_rsp;
  logic [7:0]  cmd_out_rsp_sz;
  logic        ireq_valid, ireq_ready;
  logic [7:0]  ireq_cmd, ireq_sz;
  logic [31:0] ireq_params;
  logic        irsp_valid, irsp_ready;
  logic [31:0] irsp_data;
  logic [7:0]  irsp_sz;
  logic        oreq_valid, oreq_ready;
  logic [7:0]  oreq_cmd, oreq_sz;
  logic [31:0] oreq_params;
  logic        orsp_valid, orsp_ready;
  logic [31:0] orsp_data;
  logic [7:0]  orsp_sz;

  int checks;
  int failures;

  tblink_rpc_cmd_client #(
    .CMD_IN_PARAMS_SZ(4), .CMD_IN_RSP_SZ(4), .CMD_OUT_PARAMS_SZ(4), .CMD_OUT_RSP_SZ(4)
  ) dut (
    .uclock(uclock), .reset(reset),
    .cmd_in(cmd_in), .cmd_in_sz(cmd_in_sz), .cmd_in_params(cmd_in_params),
    .cmd_in_put_i(cmd_in_put_i), .cmd_in_get_i(cmd_in_get_i),
    .cmd_in_rsp(cmd_in_rsp), .cmd_in_rsp_sz(cmd_in_rsp_sz),
    .cmd_out(cmd_out), .cmd_out_sz(cmd_out_sz), .cmd_out_params(cmd_out_params),
    .cmd_out_put_i(cmd_out_put_i), .cmd_out_get_i(cmd_out_get_i),
    .cmd_out_rsp(cmd_out_rsp), .cmd_out_rsp_sz(cmd_out_rsp_sz),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_cmd(ireq_cmd),
    .ireq_sz(ireq_sz), .ireq_params(ireq_params),
    .irsp_valid(irsp_valid), .irsp_ready(irsp_ready), .irsp_data(irsp_data), .irsp_sz(irsp_sz),
    .oreq_valid(oreq_valid), .oreq_ready(oreq_ready), .oreq_cmd(oreq_cmd),
    .oreq_sz(oreq_sz), .oreq_params(oreq_params),
    .orsp_valid(orsp_valid), .orsp_ready(orsp_ready), .orsp_data(orsp_data), .orsp_sz(orsp_sz)
  );

  initial begin
    uclock = 1'b0;
    forever #5 uclock = ~uclock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Counts every movement of the two indices this block owns.
  int   in_tog, out_tog;
  logic prev_get, prev_put;
  initial begin
    in_tog = 0; out_tog = 0; prev_get = 1'b0; prev_put = 1'b0;
    forever begin
      @(posedge uclock);
      #2;
      if (cmd_in_get_i !== prev_get) in_tog++;
      if (cmd_out_put_i !== prev_put) out_tog++;
      prev_get = cmd_in_get_i;
      prev_put = cmd_out_put_i;
    end
  end

  task automatic tick();
    @(posedge uclock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: a byte count never exceeds its buffer capacity.
  function automatic logic [7:0] model_sat(input int sz, input int cap);
    return 8'((sz > cap) ? cap : sz);
  endfunction

  function automatic logic outputs_nonzero();
    return ireq_valid | (|ireq_cmd) | (|ireq_sz) | (|ireq_params) | irsp_ready |
           cmd_in_get_i | (|cmd_in_rsp) | (|cmd_in_rsp_sz) | (|cmd_out) | (|cmd_out_sz) |
           (|cmd_out_params) | cmd_out_put_i | oreq_ready | orsp_valid | (|orsp_data) |
           (|orsp_sz);
  endfunction

  // Acts as cmdproc (producer) and as the user (consumer) for one inbound
  // command. The toggle of put opens the cycle that starts at edge N.
  task automatic in_xact(input logic [7:0] cmd, input logic [7:0] sz, input logic [31:0] prm,
                         input logic [31:0] rsp, input logic [7:0] rsz, input logic [7:0] ersz,
                         input int req_dly, input int rsp_dly);
    logic old_get, new_get;
    int   errs;
    old_get = cmd_in_get_i;
    new_get = ~old_get;
    cmd_in = cmd; cmd_in_sz = sz; cmd_in_params = prm;
    cmd_in_put_i = ~cmd_in_put_i;
    ireq_ready = 1'b0;
    chk("ireq_not_early", 64'(ireq_valid), 64'(0));
    tick();
    chk("ireq_valid", 64'(ireq_valid), 64'(1));
    chk("ireq_cmd", 64'(ireq_cmd), 64'(cmd));
    chk("ireq_sz", 64'(ireq_sz), 64'(sz));
    chk("ireq_params", 64'(ireq_params), 64'(prm));
    errs = 0;
    repeat (req_dly) begin
      tick();
      if (!ireq_valid || ireq_cmd !== cmd || ireq_sz !== sz || ireq_params !== prm ||
          cmd_in_get_i !== old_get || irsp_ready) errs++;
    end
    chk("ireq_hold", 64'(errs), 64'(0));
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    chk("ireq_drop", 64'(ireq_valid), 64'(0));
    chk("irsp_ready", 64'(irsp_ready), 64'(1));
    errs = 0;
    repeat (rsp_dly) begin
      tick();
      if (!irsp_ready || cmd_in_get_i !== old_get) errs++;
    end
    chk("irsp_wait", 64'(errs), 64'(0));
    // irsp handshake cycle opens at edge M
    irsp_valid = 1'b1; irsp_data = rsp; irsp_sz = rsz;
    tick();
    irsp_valid = 1'b0; irsp_data = $urandom; irsp_sz = 8'($urandom);
    chk("in_rsp", 64'(cmd_in_rsp), 64'(rsp));
    chk("in_rsp_sz", 64'(cmd_in_rsp_sz), 64'(ersz));
    chk("in_get_m1", 64'(cmd_in_get_i), 64'(old_get));
    chk("irsp_ready_off", 64'(irsp_ready), 64'(0));
    tick();
    chk("in_get_m2", 64'(cmd_in_get_i), 64'(new_get));
    chk("in_rsp_stable", 64'(cmd_in_rsp), 64'(rsp));
    tick();
    chk("in_no_dup", 64'({ireq_valid, cmd_in_get_i}), 64'({1'b0, new_get}));
  endtask

  // Acts as the user (requester) and cmdproc (responder) for one outbound
  // command. The oreq handshake cycle starts at edge N.
  task automatic out_xact(input logic [7:0] cmd, input logic [7:0] sz, input logic [31:0] prm,
                          input logic [7:0] esz, input logic [31:0] rsp, input logic [7:0] rsz,
                          input int get_dly, input int ack_dly);
    logic old_put, new_put;
    int   errs;
    for (int i = 0; i < 20 && !oreq_ready; i++) tick();
    chk("oreq_ready", 64'(oreq_ready), 64'(1));
    old_put = cmd_out_put_i;
    new_put = ~old_put;
    oreq_valid = 1'b1; oreq_cmd = cmd; oreq_sz = sz; oreq_params = prm;
    tick();
    oreq_valid = 1'b0; oreq_cmd = 8'($urandom); oreq_sz = 8'($urandom); oreq_params = $urandom;
    chk("cmd_out", 64'(cmd_out), 64'(cmd));
    chk("cmd_out_sz", 64'(cmd_out_sz), 64'(esz));
    chk("cmd_out_params", 64'(cmd_out_params), 64'(prm));
    chk("out_put_n1", 64'({cmd_out_put_i, oreq_ready}), 64'({old_put, 1'b0}));
    tick();
    chk("out_put_n2", 64'(cmd_out_put_i), 64'(new_put));
    chk("cmd_out_stable", 64'({cmd_out, cmd_out_sz, cmd_out_params}), 64'({cmd, esz, prm}));
    errs = 0;
    repeat (get_dly) begin
      tick();
      if (orsp_valid || cmd_out_put_i !== new_put) errs++;
    end
    chk("out_wait", 64'(errs), 64'(0));
    // get==put holds from edge K onward
    cmd_out_rsp = rsp; cmd_out_rsp_sz = rsz;
    cmd_out_get_i = ~cmd_out_get_i;
    chk("orsp_not_early", 64'(orsp_valid), 64'(0));
    tick();
    chk("orsp_valid", 64'(orsp_valid), 64'(1));
    chk("orsp_data", 64'(orsp_data), 64'(rsp));
    chk("orsp_sz", 64'(orsp_sz), 64'(rsz));
    cmd_out_rsp = $urandom; cmd_out_rsp_sz = 8'($urandom);
    errs = 0;
    repeat (ack_dly) begin
      tick();
      if (!orsp_valid || orsp_data !== rsp || orsp_sz !== rsz) errs++;
    end
    chk("orsp_hold", 64'(errs), 64'(0));
    orsp_ready = 1'b1;
    tick();
    orsp_ready = 1'b0;
    chk("orsp_done", 64'({orsp_valid, oreq_ready}), 64'({1'b0, 1'b1}));
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  sz;
    logic [31:0] params;
    logic [31:0] rsp;
    logic [7:0]  rsp_sz;
    logic [7:0]  exp_rsp_sz;
  } in_vec_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  sz;
    logic [31:0] params;
    logic [7:0]  exp_sz;
    logic [31:0] rsp;
    logic [7:0]  rsp_sz;
  } out_vec_t;

  in_vec_t  in_tbl[4];
  out_vec_t out_tbl[3];
  int       base_in, base_out;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    cmd_in = '0; cmd_in_sz = '0; cmd_in_params = '0; cmd_in_put_i = 1'b0;
    cmd_out_get_i = 1'b0; cmd_out_rsp = '0; cmd_out_rsp_sz = '0;
    ireq_ready = 1'b0; irsp_valid = 1'b0; irsp_data = '0; irsp_sz = '0;
    oreq_valid = 1'b0; oreq_cmd = '0; oreq_sz = '0; oreq_params = '0;
    orsp_ready = 1'b0;

    in_tbl[0] = '{8'h12, 8'd2,   32'h0000BEEF, 32'h0000CAFE, 8'd2, 8'd2};
    in_tbl[1] = '{8'h7F, 8'd4,   32'hDEADBEEF, 32'h11223344, 8'd9, 8'd4};
    in_tbl[2] = '{8'h00, 8'd0,   32'h00000000, 32'hFFFFFFFF, 8'd4, 8'd4};
    in_tbl[3] = '{8'hFF, 8'd200, 32'hA5A5A5A5, 32'h00000000, 8'd5, 8'd4};
    out_tbl[0] = '{8'h40, 8'd4, 32'h01020304, 8'd4, 32'h00000055, 8'd1};
    out_tbl[1] = '{8'h41, 8'd7, 32'hCAFEF00D, 8'd4, 32'h12345678, 8'd4};
    out_tbl[2] = '{8'h42, 8'd1, 32'h000000AA, 8'd1, 32'h00000000, 8'd9};

    tick(); tick();
    chk("reset_outputs", 64'(outputs_nonzero()), 64'(0));
    reset = 1'b0;
    tick();
    chk("post_reset_ready", 64'({oreq_ready, ireq_valid}), 64'({1'b1, 1'b0}));

    for (int i = 0; i < 4; i++)
      in_xact(in_tbl[i].cmd, in_tbl[i].sz, in_tbl[i].params, in_tbl[i].rsp,
              in_tbl[i].rsp_sz, in_tbl[i].exp_rsp_sz, 0, 0);
    for (int i = 0; i < 3; i++)
      out_xact(out_tbl[i].cmd, out_tbl[i].sz, out_tbl[i].params, out_tbl[i].exp_sz,
               out_tbl[i].rsp, out_tbl[i].rsp_sz, i, i + 1);

    // inbound backpressure: ten cycles without ireq_ready
    in_xact(8'h21, 8'd3, 32'h00ABCDEF, 32'h0BADF00D, 8'd3, 8'd3, 10, 2);

    // reset while inbound sits in WAIT_RSP and outbound in WAIT
    for (int i = 0; i < 20 && !oreq_ready; i++) tick();
    cmd_in = 8'h33; cmd_in_sz = 8'd1; cmd_in_params = 32'h00000077;
    cmd_in_put_i = ~cmd_in_put_i;
    ireq_ready = 1'b1;
    oreq_valid = 1'b1; oreq_cmd = 8'h44; oreq_sz = 8'd2; oreq_params = 32'h00001234;
    tick();
    oreq_valid = 1'b0;
    tick();
    ireq_ready = 1'b0;
    chk("pre_reset_busy", 64'({irsp_ready, orsp_valid, oreq_ready}), 64'({1'b1, 1'b0, 1'b0}));
    reset = 1'b1;
    cmd_in_put_i = 1'b0;
    cmd_out_get_i = 1'b0;
    tick();
    reset = 1'b0;
    chk("midreset_outputs", 64'(outputs_nonzero()), 64'(0));
    chk("midreset_indices", 64'({cmd_in_get_i, cmd_out_put_i}), 64'(0));
    tick();
    chk("midreset_dropped", 64'({ireq_valid, oreq_ready}), 64'({1'b0, 1'b1}));
    in_xact(8'h12, 8'd2, 32'h0000BEEF, 32'h0000CAFE, 8'd2, 8'd2, 1, 1);
    out_xact(8'h40, 8'd4, 32'h01020304, 8'd4, 32'h00000055, 8'd1, 0, 0);

    // concurrent random traffic on both directions
    base_in = in_tog;
    base_out = out_tog;
    fork
      begin
        for (int n = 0; n < 50; n++) begin
          logic [7:0]  c, s, rs;
          logic [31:0] p, r;
          c = 8'($urandom); s = 8'($urandom_range(0, 12)); p = $urandom;
          r = $urandom; rs = 8'($urandom_range(0, 12));
          repeat ($urandom_range(0, 3)) tick();
          in_xact(c, s, p, r, rs, model_sat(int'(rs), 4),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
      end
      begin
        for (int n = 0; n < 50; n++) begin
          logic [7:0]  c, s, rs;
          logic [31:0] p, r;
          c = 8'($urandom); s = 8'($urandom_range(0, 12)); p = $urandom;
          r = $urandom; rs = 8'($urandom);
          repeat ($urandom_range(0, 3)) tick();
          out_xact(c, s, p, model_sat(int'(s), 4), r, rs,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end
      end
    join
    tick(); tick();
    chk("in_get_toggles", 64'(in_tog - base_in), 64'(50));
    chk("out_put_toggles", 64'(out_tog - base_out), 64'(50));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
